// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the 2x2 streaming max-pool engine.
// Lane slice macro MP_LANE selects lane k of a packed multi-lane word.
`ifndef MAXPOOL_PKG_SV
`define MAXPOOL_PKG_SV
`define MP_LANE(v, k, w) v[(k)*(w) +: (w)]

package maxpool_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  localparam int MAX_W = 32;

  function automatic logic signed [MAX_W-1:0] max2(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage
`endif

// File: rtl/maxpool_lane_max4.sv
// Two-stage signed 4-input maximum for one channel lane.
// Stage 1 takes pairwise maxima, stage 2 the final maximum.
module maxpool_lane_max4
  import maxpool_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] d,
  output logic signed [WIDTH-1:0] y
);

  logic signed [WIDTH-1:0] m0;
  logic signed [WIDTH-1:0] m1;

  // pairwise then final max, both frozen while en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      m0 <= '0;
      m1 <= '0;
      y  <= '0;
    end else if (en) begin
      m0 <= WIDTH'(max2(MAX_W'(a), MAX_W'(b)));
      m1 <= WIDTH'(max2(MAX_W'(c), MAX_W'(d)));
      y  <= WIDTH'(max2(MAX_W'(m0), MAX_W'(m1)));
    end
  end

endmodule

// File: rtl/maxpool_stream_engine.sv
// Streaming 2x2 max-pool: line buffer, raster counters, FSM, 2-stage compare.
// Define MAXPOOL_STRIDE1_EN to build stride-1 mode with edge replication.
module maxpool_stream_engine
  import maxpool_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CH       = 8,
  parameter int MAX_COLS = 416,
  parameter int COL_W    = 9,
  parameter int ROW_W    = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [COL_W-1:0]    cfg_cols,
  input  logic [ROW_W-1:0]    cfg_rows,
  input  logic                cfg_stride1,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*WIDTH-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int DW = CH * WIDTH;
  localparam logic [COL_W:0] MAXC = (COL_W+1)'(MAX_COLS);

  state_t           state;
  logic [COL_W-1:0] cols_q, col, lastc_q;
  logic [ROW_W-1:0] rows_q, row, lastr_q;
  logic             fin_q;
  logic [DW-1:0]    lb [MAX_COLS];
  logic [DW-1:0]    lb_rd, prev_q, prevup_q;
  logic [DW-1:0]    wa, wb, wc, wd;
  logic en, acc, ohs, in_last, win_last;
  logic want, v1, l1, legal, s1_ok, s1;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = (state == S_RUN) && en;
  assign acc      = in_valid && in_ready;
  assign ohs      = out_valid && out_ready && out_last;
  assign lb_rd    = lb[col];
  assign in_last  = (col == cols_q - COL_W'(1)) &&
                    (row == rows_q - ROW_W'(1));

`ifdef MAXPOOL_STRIDE1_EN
  logic s1_q;
  logic r0, c0;
  assign s1    = s1_q;
  assign s1_ok = 1'b1;
  assign r0    = s1_q && (row == '0);
  assign c0    = s1_q && (col == '0);

  // clamp r-1 / c-1 to the frame edge in stride-1 mode
  always_comb begin
    wd = in_data;
    wb = r0 ? in_data : lb_rd;
    wc = c0 ? in_data : prev_q;
    wa = prevup_q;
    if (r0 && c0) wa = in_data;
    else if (r0)  wa = prev_q;
    else if (c0)  wa = lb_rd;
  end
`else
  assign s1    = 1'b0;
  assign s1_ok = !cfg_stride1;
  assign wa    = prevup_q;
  assign wb    = lb_rd;
  assign wc    = prev_q;
  assign wd    = in_data;
`endif

  assign legal = (cfg_cols >= COL_W'(2)) &&
                 (cfg_rows >= ROW_W'(2)) &&
                 ({1'b0, cfg_cols} <= MAXC) && s1_ok;
  assign want     = s1 || (row[0] && col[0]);
  assign win_last = s1 ? in_last
                       : (col == lastc_q) && (row == lastr_q);

  // line buffer keeps row r-1; prev regs give the c-1 column
  always_ff @(posedge clk) begin
    if (acc) begin
      lb[col]  <= in_data;
      prev_q   <= in_data;
      prevup_q <= lb_rd;
    end
  end

  // frame control, counters and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      col     <= '0;
      row     <= '0;
      cols_q  <= '0;
      rows_q  <= '0;
      lastc_q <= '0;
      lastr_q <= '0;
      fin_q   <= 1'b0;
`ifdef MAXPOOL_STRIDE1_EN
      s1_q    <= 1'b0;
`endif
    end else begin
      done    <= ohs;
      cfg_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && legal) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            col     <= '0;
            row     <= '0;
            fin_q   <= 1'b0;
            cols_q  <= cfg_cols;
            rows_q  <= cfg_rows;
            lastc_q <= {cfg_cols[COL_W-1:1], 1'b0} - COL_W'(1);
            lastr_q <= {cfg_rows[ROW_W-1:1], 1'b0} - ROW_W'(1);
`ifdef MAXPOOL_STRIDE1_EN
            s1_q    <= cfg_stride1;
`endif
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        S_RUN: begin
          if (ohs) fin_q <= 1'b1;
          if (acc) begin
            if (col == cols_q - COL_W'(1)) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
            if (in_last) begin
              if (fin_q || ohs) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          if (ohs) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // valid/last travel alongside the two compare stages
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      l1        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      v1        <= acc && want;
      l1        <= acc && want && win_last;
      out_valid <= v1;
      out_last  <= l1;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    maxpool_lane_max4 #(.WIDTH(WIDTH)) u_max (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (`MP_LANE(wa, k, WIDTH)),
      .b   (`MP_LANE(wb, k, WIDTH)),
      .c   (`MP_LANE(wc, k, WIDTH)),
      .d   (`MP_LANE(wd, k, WIDTH)),
      .y   (`MP_LANE(out_data, k, WIDTH))
    );
  end

endmodule

// File: tb/tb_maxpool_stream_engine.sv
// Randomized scoreboard bench for maxpool_stream_engine.
// Expected beats come from a block/window max model over a pixel array.
module tb_maxpool_stream_engine;

  localparam int WIDTH    = 8;
  localparam int CH       = 8;
  localparam int MAX_COLS = 416;
  localparam int COL_W    = 9;
  localparam int ROW_W    = 9;
  localparam int DW       = CH * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [COL_W-1:0] cfg_cols = '0;
  logic [ROW_W-1:0] cfg_rows = '0;
  logic             cfg_stride1 = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             busy, done, cfg_err;

  maxpool_stream_engine #(
    .WIDTH(WIDTH), .CH(CH), .MAX_COLS(MAX_COLS),
    .COL_W(COL_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .cfg_stride1(cfg_stride1),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] pix [0:15][0:15];
  bit            rdy_rand = 0;
  bit            gaps = 0;
  bit            done_seen = 0;
  bit            lhs_prev = 0;
  bit            stuck = 0;

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // per-lane signed max over pixel rectangle rows r0..r1, cols c0..c1
  function automatic logic [DW-1:0] win(int r0, int r1, int c0, int c1);
    logic [DW-1:0] res;
    logic signed [WIDTH-1:0] m, v;
    res = '0;
    for (int k = 0; k < CH; k++) begin
      m = pix[r0][c0][k*WIDTH +: WIDTH];
      for (int r = r0; r <= r1; r++)
        for (int c = c0; c <= c1; c++) begin
          v = pix[r][c][k*WIDTH +: WIDTH];
          if (v > m) m = v;
        end
      res[k*WIDTH +: WIDTH] = m;
    end
    return res;
  endfunction

  task automatic fill(input int cols, input int rows, input int mode);
    int idx, val;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        idx = r * cols + c;
        for (int k = 0; k < CH; k++) begin
          case (mode)
            0:       val = idx + k;
            1:       val = cols * rows - 1 - idx + k;
            default: val = int'($urandom_range(0, 255));
          endcase
          pix[r][c][k*WIDTH +: WIDTH] = WIDTH'(val);
        end
      end
  endtask

  // downstream ready: always 1 or a 50% coin per cycle
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // scoreboard monitor: pops one expectation per output handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (lhs_prev || done) chkb("done_pulse", done, lhs_prev);
      if (done) done_seen = 1;
      if (out_valid && !out_ready)
        chkb("stall_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out got=%h want=none", out_data);
        end else begin
          e = q.pop_front();
          chkd("out_data", out_data, e.d);
          chkb("out_last", out_last, e.l);
        end
      end
      lhs_prev = out_valid && out_ready && out_last;
    end else begin
      lhs_prev = 0;
    end
  end

  task automatic pulse_start(input int cols, input int rows, input bit s1);
    @(posedge clk);
    #1;
    cfg_cols    = COL_W'(cols);
    cfg_rows    = ROW_W'(rows);
    cfg_stride1 = s1;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    bit ok;
    if (stuck) return;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    n  = 0;
    ok = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      stuck = 1;
      $display("FAIL in_ready_timeout got=0 want=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int cols, input int rows, input bit s1);
    exp_t e;
    int n;
    if (s1) begin
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++) begin
          e.d = win(r > 0 ? r - 1 : 0, r, c > 0 ? c - 1 : 0, c);
          e.l = (r == rows - 1) && (c == cols - 1);
          q.push_back(e);
        end
    end else begin
      for (int i = 0; i < rows / 2; i++)
        for (int j = 0; j < cols / 2; j++) begin
          e.d = win(2 * i, 2 * i + 1, 2 * j, 2 * j + 1);
          e.l = (i == rows / 2 - 1) && (j == cols / 2 - 1);
          q.push_back(e);
        end
    end
    done_seen = 0;
    pulse_start(cols, rows, s1);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        send(pix[r][c]);
    n = 0;
    while (!done_seen && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chkb("frame_done", done_seen, 1'b1);
    chkb("queue_drained", q.size() == 0, 1'b1);
    chkb("idle_after", busy, 1'b0);
    q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    start    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    chkb({tag, "_out_valid"}, out_valid, 1'b0);
    chkb({tag, "_out_last"}, out_last, 1'b0);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_done"}, done, 1'b0);
    chkb({tag, "_cfg_err"}, cfg_err, 1'b0);
    chkb({tag, "_in_ready"}, in_ready, 1'b0);
    chkd({tag, "_out_data"}, out_data, '0);
  endtask

  task automatic bad_cfg(input string nm, input int cols, input int rows,
                         input bit s1);
    pulse_start(cols, rows, s1);
    @(negedge clk);
    chkb({nm, "_err"}, cfg_err, 1'b1);
    chkb({nm, "_busy"}, busy, 1'b0);
    @(negedge clk);
    chkb({nm, "_err_clear"}, cfg_err, 1'b0);
    chkb({nm, "_still_idle"}, busy, 1'b0);
  endtask

  initial begin
    exp_t e;
    bit s1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("reset");

    fill(4, 4, 0);
    run_frame(4, 4, 0);

    fill(5, 5, 0);
    run_frame(5, 5, 0);

    fill(2, 2, 2);
    pix[0][0][7:0]  = 8'h80;
    pix[0][1][7:0]  = 8'hFF;
    pix[1][0][7:0]  = 8'hF9;
    pix[1][1][7:0]  = 8'h80;
    pix[0][0][15:8] = 8'h80;
    pix[0][1][15:8] = 8'h80;
    pix[1][0][15:8] = 8'h80;
    pix[1][1][15:8] = 8'h80;
    run_frame(2, 2, 0);

`ifdef MAXPOOL_STRIDE1_EN
    fill(3, 3, 1);
    run_frame(3, 3, 1);
`else
    bad_cfg("stride1_off", 4, 4, 1'b1);
`endif

    rdy_rand = 1;
    gaps     = 1;
    fill(6, 4, 2);
    run_frame(6, 4, 0);
    for (int t = 0; t < 8; t++) begin
      int cols, rows;
      cols = int'($urandom_range(2, 12));
      rows = int'($urandom_range(2, 9));
`ifdef MAXPOOL_STRIDE1_EN
      s1 = 1'($urandom_range(0, 1));
`else
      s1 = 1'b0;
`endif
      fill(cols, rows, 2);
      run_frame(cols, rows, s1);
    end
    rdy_rand = 0;
    gaps     = 0;
    @(posedge clk);

    fill(4, 4, 2);
    e.d = win(0, 1, 0, 1);
    e.l = 1'b0;
    q.push_back(e);
    pulse_start(4, 4, 0);
    for (int i = 0; i < 6; i++) send(pix[i / 4][i % 4]);
    do_reset();
    check_quiet("mid_reset");

    fill(4, 4, 0);
    run_frame(4, 4, 0);

    bad_cfg("cols_one", 1, 4, 1'b0);
    bad_cfg("cols_over", MAX_COLS + 1, 4, 1'b0);
    bad_cfg("rows_one", 4, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
